// File: rtl/bcd_converter.sv
// bcd_converter
//   Memory-mapped binary-to-BCD converter that drives the digital tube device.
//   The CPU writes a signed 32-bit value to VALUE. Its magnitude is clamped to
//   9999999, converted by a double-dabble engine (one bit per clock, 24
//   iterations), and the 7-digit BCD result is sent to the tube as a
//   one-cycle write. Negative inputs are sent two's-complemented so the
//   tube lights its sign segment.
//
// Ports
//   clk      in   1   clock
//   reset    in   1   synchronous, active-high reset
//   we       in   1   bus write strobe, already decoded for this device
//   addr     in  32   byte address; addr[3:2] selects the register
//   wd       in  32   bus write data
//   RD       out 32   bus read data (combinational)
//   busy     out  1   conversion in progress
//   tube_we  out  1   one-cycle write strobe to the tube device
//   tube_wd  out 32   tube data, zero unless tube_we is high
//
// Register map (byte offsets from BASE)
//   0x0 VALUE  R/W  last written signed value
//   0x4 STATUS R    {29'b0, ovf, done, busy}
//   0x8 RESULT R    unsigned 7-digit BCD, [31:28] = 0
//   0xC        R    reads 0
//
// State table
//   state  | meaning
//   IDLE   | waiting for a VALUE write
//   CONV   | double-dabble running, one magnitude bit per clock
//   EMIT   | result presented to the tube for exactly one cycle

`ifndef DEV5ADDR_BEGIN
`define DEV5ADDR_BEGIN 32'h0000_7F60
`endif

module bcd_converter #(
  parameter logic [31:0] BASE = `DEV5ADDR_BEGIN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] RD,
  output logic        busy,
  output logic        tube_we,
  output logic [31:0] tube_wd
);

  localparam logic [23:0] MAX_MAG   = 24'd9999999;
  localparam logic [4:0]  LAST_ITER = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] value_q;
  logic [31:0] result_q;
  logic        neg_q;
  logic        ovf_q;
  logic        done_q;
  logic [27:0] bcd_q;
  logic [23:0] mag_q;
  logic [4:0]  iter_cnt_q;

  // ---------------------------------------------------------------------------
  // Address decode. BASE is 16-byte aligned, so the window offset's [3:2]
  // equals addr[3:2]; subtracting keeps the decode tied to the window base.
  // ---------------------------------------------------------------------------
  logic [31:0] win_off;
  logic [1:0]  reg_sel;
  logic        value_wr;
  logic        unused_off_bits;

  assign win_off         = addr - BASE;
  assign reg_sel         = win_off[3:2];
  assign unused_off_bits = ^{win_off[31:4], win_off[1:0]};
  assign value_wr        = we && (reg_sel == 2'd0);

  // ---------------------------------------------------------------------------
  // Input magnitude and clamp. 0x80000000 negates to itself, which as an
  // unsigned number is 2147483648 and therefore clamps like any other
  // out-of-range value.
  // ---------------------------------------------------------------------------
  logic [31:0] in_mag;
  logic        in_ovf;
  logic [23:0] in_mag_clamped;

  always_comb begin
    in_mag         = wd[31] ? (~wd + 32'd1) : wd;
    in_ovf         = (in_mag > {8'd0, MAX_MAG});
    in_mag_clamped = in_ovf ? MAX_MAG : in_mag[23:0];
  end

  // ---------------------------------------------------------------------------
  // One double-dabble iteration: correct every digit >= 5, then shift the
  // combined {bcd, mag} register left by one.
  // ---------------------------------------------------------------------------
  function automatic logic [27:0] add3_digits(input logic [27:0] b);
    logic [27:0] r;
    r = b;
    for (int i = 0; i < 7; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  logic [27:0] bcd_adj;
  logic [27:0] bcd_shifted;
  logic [23:0] mag_shifted;

  always_comb begin
    bcd_adj                    = add3_digits(bcd_q);
    {bcd_shifted, mag_shifted} = {bcd_adj[26:0], mag_q, 1'b0};
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and strobes. A VALUE write always restarts the engine;
  // in EMIT it also withholds the tube write so the aborted result is never
  // seen by the tube nor stored in RESULT.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tube_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (value_wr) begin
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (value_wr) begin
          state_d = S_CONV;
        end else if (iter_cnt_q == 5'd0) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (value_wr) begin
          state_d = S_CONV;
        end else begin
          tube_we = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Datapath. The iteration counter runs down from 23; the iteration that
  // sees zero is the 24th and last one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q    <= 32'd0;
      result_q   <= 32'd0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= 28'd0;
      mag_q      <= 24'd0;
      iter_cnt_q <= 5'd0;
    end else if (value_wr) begin
      value_q    <= wd;
      neg_q      <= wd[31];
      ovf_q      <= in_ovf;
      done_q     <= 1'b0;
      bcd_q      <= 28'd0;
      mag_q      <= in_mag_clamped;
      iter_cnt_q <= LAST_ITER;
    end else if (state_q == S_CONV) begin
      bcd_q <= bcd_shifted;
      mag_q <= mag_shifted;
      if (iter_cnt_q != 5'd0) begin
        iter_cnt_q <= iter_cnt_q - 5'd1;
      end
    end else if (tube_we) begin
      result_q <= {4'd0, bcd_q};
      done_q   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tube data: the tube re-negates values with bit 31 set and lights NEG.
  // ---------------------------------------------------------------------------
  logic [31:0] bcd_word;

  always_comb begin
    bcd_word = {4'd0, bcd_q};
    tube_wd  = 32'd0;
    if (tube_we) begin
      tube_wd = neg_q ? (~bcd_word + 32'd1) : bcd_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    RD = 32'd0;
    if (!reset) begin
      case (reg_sel)
        2'd0:    RD = value_q;
        2'd1:    RD = {29'd0, ovf_q, done_q, busy};
        2'd2:    RD = result_q;
        default: RD = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
module tb_bcd_converter;

  localparam logic [31:0] BASE = 32'h0000_7F60;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        busy;
  logic        tube_we;
  logic [31:0] tube_wd;

  bcd_converter #(.BASE(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .addr    (addr),
    .wd      (wd),
    .RD      (rd),
    .busy    (busy),
    .tube_we (tube_we),
    .tube_wd (tube_wd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] tube;
    logic [31:0] bcd;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_value;
  logic [31:0] m_result;
  logic        m_ovf;
  logic        m_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic on the magnitude.
  function automatic logic [31:0] to_bcd(input longint m);
    logic [31:0] r;
    longint      v;
    r = 32'd0;
    v = m;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Any VALUE write replaces whatever conversion was pending.
  task automatic model_write(input logic [31:0] d);
    longint s;
    longint mag;
    exp_t   e;
    s       = longint'(signed'(d));
    mag     = (s < 0) ? -s : s;
    m_ovf   = (mag > 9999999);
    if (m_ovf) mag = 9999999;
    m_value = d;
    m_done  = 1'b0;
    e.bcd   = to_bcd(mag);
    e.tube  = (s < 0) ? (32'd0 - e.bcd) : e.bcd;
    e.issue = cyc;
    sb.delete();
    sb.push_back(e);
  endtask

  // Monitor: every tube strobe must match the oldest expected emission.
  always @(negedge clk) begin
    if (tube_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tube_we: got tube_wd %08h expected no pulse", tube_wd);
      end else begin
        mon_e = sb.pop_front();
        chk("tube_wd", tube_wd, mon_e.tube);
        chk("tube_latency", 32'(cyc - mon_e.issue), 32'd25);
        m_result = mon_e.bcd;
        m_done   = 1'b1;
      end
    end
  end

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
    @(posedge clk); #1;
    we   = 1'b1;
    addr = BASE + {28'd0, off, 2'b00};
    wd   = d;
    if (off == 2'd0) model_write(d);
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic read_chk(input string nm, input logic [1:0] off, input logic [31:0] exp);
    @(posedge clk); #1;
    addr = BASE + {28'd0, off, 2'b00};
    #2;
    chk(nm, rd, exp);
  endtask

  task automatic check_regs();
    read_chk("value",  2'd0, m_value);
    read_chk("status", 2'd1, {29'd0, m_ovf, m_done, (sb.size() != 0)});
    read_chk("result", 2'd2, m_result);
    read_chk("off_c",  2'd3, 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no tube_we within 40 cycles, expected tube_wd %08h", sb[0].tube);
      sb.delete();
    end
    @(posedge clk);
  endtask

  initial begin
    int sel;
    int dly;
    logic [31:0] v;

    reset    = 1'b1;
    we       = 1'b0;
    addr     = BASE;
    wd       = 32'd0;
    m_value  = 32'd0;
    m_result = 32'd0;
    m_ovf    = 1'b0;
    m_done   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd",      rd,              32'd0);
    chk("reset_busy",    {31'd0, busy},   32'd0);
    chk("reset_tube_we", {31'd0, tube_we}, 32'd0);
    chk("reset_tube_wd", tube_wd,         32'd0);
    reset = 1'b0;
    check_regs();

    // Directed cases from the register-level behaviour.
    bus_write(2'd0, 32'h0012D687);
    @(posedge clk); #1;
    chk("busy_after_write", {31'd0, busy}, 32'd1);
    wait_done();
    check_regs();

    bus_write(2'd0, 32'hFFFFFFD6);
    wait_done();
    check_regs();

    bus_write(2'd0, 32'h80000000);
    wait_done();
    check_regs();

    bus_write(2'd0, 32'h0098967F);
    wait_done();
    check_regs();

    // Restart mid-conversion: only the second value may reach the tube.
    bus_write(2'd0, 32'd5);
    repeat (8) begin
      @(posedge clk); #1;
      chk("busy_during_abort", {31'd0, busy}, 32'd1);
    end
    bus_write(2'd0, 32'd99);
    wait_done();
    check_regs();

    // Write landing in the EMIT cycle suppresses that emission.
    bus_write(2'd0, 32'd777);
    repeat (23) @(posedge clk);
    bus_write(2'd0, 32'd31337);
    wait_done();
    check_regs();

    // Reset in the middle of a conversion.
    bus_write(2'd0, 32'd1234567);
    repeat (10) @(posedge clk);
    #1;
    reset    = 1'b1;
    sb.delete();
    m_value  = 32'd0;
    m_result = 32'd0;
    m_ovf    = 1'b0;
    m_done   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = BASE + 32'(4 * i);
      #1;
      chk("rd_in_reset", rd, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    chk("busy_after_reset", {31'd0, busy}, 32'd0);
    check_regs();
    repeat (30) @(posedge clk);

    // Zero, then writes to read-only offsets.
    bus_write(2'd0, 32'd0);
    wait_done();
    check_regs();
    bus_write(2'd2, 32'h0000_1234);
    #1;
    chk("no_start_on_result_write", {31'd0, busy}, 32'd0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'h0000_0042);
    check_regs();
    repeat (30) @(posedge clk);

    // Randomized values and write spacing.
    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       v = $urandom_range(0, 999);
        1:       v = $urandom;
        2:       v = 32'(9999990 + $urandom_range(0, 19));
        default: v = 32'd0 - 32'($urandom_range(1, 20000000));
      endcase
      bus_write(2'd0, v);
      dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 26)) : 30;
      if (dly >= 30) begin
        wait_done();
        check_regs();
      end else begin
        repeat (dly) @(posedge clk);
      end
    end
    wait_done();
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_converter.md
# bcd_converter

Memory-mapped binary-to-BCD converter that feeds the digital tube device. The CPU writes a signed 32-bit binary value. The block clamps it to seven decimal digits and converts the magnitude with a sequential double-dabble engine, one bit per cycle. It then issues a one-cycle write of the result to the tube's `we`/`wd` port, so the tube shows decimal digits and its sign segment.

## Interface
Parameters:
- `BASE`, default `` `DEV5ADDR_BEGIN ``: byte base address of this device's 16-byte register window.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `we`, in, 1: bus write strobe, already decoded for this device.
- `addr`, in, 32: byte address; `addr[3:2]` selects a register at offset `BASE + 4*addr[3:2]`.
- `wd`, in, 32: bus write data.
- `RD`, out, 32: bus read data, combinational.
- `busy`, out, 1: conversion in progress.
- `tube_we`, out, 1: one-cycle write strobe to the tube device.
- `tube_wd`, out, 32: data for the tube device, valid while `tube_we` is high.

## Operation
Registers:
- 0x0 VALUE (R/W): last written signed value.
- 0x4 STATUS (R): `{29'b0, ovf, done, busy}`.
- 0x8 RESULT (R): unsigned BCD result, 7 digits, `[31:28]=0`.
- 0xC (R): reads 0.
- Writes to 0x4, 0x8 and 0xC are ignored.

Write to VALUE:
- Latch VALUE.
- Compute `neg = wd[31]` and `mag = neg ? (~wd + 1) : wd`, as 32-bit unsigned. 0x80000000 gives magnitude 2147483648.
- If `mag > 9999999`: set `ovf = 1` and replace `mag` with 9999999. Otherwise set `ovf = 0`.
- Clear `done`, clear the BCD shift register, load the 24-bit magnitude shift register, and enter CONV.

State machine:
- IDLE.
  - VALUE write → CONV.
- CONV: 24 iterations, counter 0..23. Each iteration:
  - Every BCD digit ≥ 5 gets +3.
  - Then shift `{bcd[27:0], mag[23:0]}` left by 1.
  - After iteration 23 → EMIT.
- EMIT: one cycle.
  - Drive `tube_we = 1` and `tube_wd = neg ? (~{4'b0, bcd} + 1) : {4'b0, bcd}`. The tube re-negates a value with bit 31 set and lights NEG.
  - Store RESULT, set `done = 1`, → IDLE.

Outputs:
- `busy = (state != IDLE)`.
- `tube_wd` is 0 when `tube_we` is low.
- `RD = reset ? 0 : selected register`.

Boundary conditions:
- VALUE write while in CONV or EMIT aborts the current conversion and restarts from the new value. The aborted conversion produces no `tube_we` and RESULT is unchanged. A write in the same cycle as EMIT suppresses that EMIT.
- A value of 0 converts normally to BCD 0 with `neg = 0`.
- −0 cannot occur.
- Reset mid-operation clears everything: state IDLE, all registers 0, `tube_we` 0. No partial result is emitted.

## Timing
- Reset values: `RD`=0, `busy`=0, `tube_we`=0, `tube_wd`=0. VALUE, RESULT, `ovf` and `done` are all 0.
- A VALUE write is sampled at clock edge T.
- `busy` is high from after edge T.
- CONV iterations occur at edges T+1 through T+24.
- `tube_we` is high in the cycle after edge T+24. The tube captures the data at edge T+25.
- `busy` and `tube_we` fall and `done` rises after edge T+25.
- Total latency from write to tube capture: 25 cycles.
- Only one conversion is ever in flight; there is no queueing.

## Test plan
- Write 0x0012D687 (1234567) → 25 cycles later a single `tube_we` pulse with `tube_wd`=0x01234567. RESULT=0x01234567, STATUS=0b010.
- Write 0xFFFFFFD6 (−42) → `tube_wd`=0xFFFFFFBE, RESULT=0x00000042, STATUS=0b010.
- Write 0x80000000 → `ovf`=1, RESULT=0x09999999, `tube_wd`=0xF6666667, STATUS=0b110. Write 0x0098967F (9999999) → RESULT=0x09999999, `ovf`=0.
- Write 5, then write 99 ten cycles later → exactly one `tube_we`, with `tube_wd`=0x00000099, 25 cycles after the second write. `busy` stays high throughout.
- Write 1234567, assert `reset` at cycle 12 → `busy`=0, no `tube_we` ever, and every `RD` offset returns 0.
- Write 0 → `tube_wd`=0x00000000 after 25 cycles. Read offset 0xC → 0. Write to 0x8 → RESULT unchanged and no conversion starts.
